// File: rtl/adder_pkg.sv
// adder_pkg
//   Shared types and helpers for the chunked serial adder and its bench.
//   adder_state_t : controller state (IDLE, CALC, DONE)
//   idx_width()   : chunk index width, never less than one bit
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// adder_nbit
//   Combinational unsigned adder: {overflow, sum} = a + b + carry_in.
//   Ports:
//     a, b      in  BIT_WIDTH  operands
//     carry_in  in  1          carry into bit 0
//     sum       out BIT_WIDTH  low BIT_WIDTH bits of the total
//     overflow  out 1          carry out of the top bit
module adder_nbit #(
  parameter int unsigned BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);

  logic [BIT_WIDTH:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};
  end

  assign sum      = total[BIT_WIDTH-1:0];
  assign overflow = total[BIT_WIDTH];

endmodule

// File: rtl/adder_nbit_serial.sv
// adder_nbit_serial
//   Multi-cycle unsigned adder. Operands are captured on an accepted start, then
//   CHUNK_BITS are added per clock, LSB chunk first, with the carry held in a
//   register between chunks. sum/overflow change only when the last chunk lands.
//   Ports:
//     clk       in  1         rising-edge clock
//     n_rst     in  1         synchronous active-low reset
//     start     in  1         request a new add (accepted in IDLE or DONE)
//     a, b      in  NUM_BITS  operands, captured on accepted start
//     carry_in  in  1         carry into bit 0, captured on accepted start
//     busy      out 1         high exactly while in CALC
//     done      out 1         one-cycle pulse, result valid and new
//     sum       out NUM_BITS  (a + b + carry_in) mod 2**NUM_BITS
//     overflow  out 1         carry out of bit NUM_BITS-1
module adder_nbit_serial
  import adder_pkg::*;
#(
  parameter int unsigned NUM_BITS   = 16,
  parameter int unsigned CHUNK_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow
);

  // ChunkW keeps port widths legal long enough for the parameter check to fire.
  localparam int unsigned ChunkW    = (CHUNK_BITS > 0) ? CHUNK_BITS : 1;
  localparam int unsigned NumChunks = NUM_BITS / ChunkW;
  localparam int unsigned IdxW      = idx_width(NumChunks);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

  if (CHUNK_BITS < 1 || (NUM_BITS % ChunkW) != 0) begin : g_param_err
    $error("adder_nbit_serial: CHUNK_BITS must be >= 1 and divide NUM_BITS");
  end

  adder_state_t        state_q;
  logic [NUM_BITS-1:0] a_q, b_q;
  logic                carry_q;
  logic [IdxW-1:0]     idx_q;
  logic [NUM_BITS-1:0] result_q, result_d;
  logic [NUM_BITS-1:0] sum_q;
  logic                overflow_q;

  logic [ChunkW-1:0]   a_chunk, b_chunk, chunk_sum;
  logic                chunk_cout;
  logic                accept;

  // Start is honoured only when no computation is in flight.
  assign accept = start && (state_q == IDLE || state_q == DONE);

  // Operand chunk mux.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < NumChunks; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_chunk = a_q[i*ChunkW +: ChunkW];
        b_chunk = b_q[i*ChunkW +: ChunkW];
      end
    end
  end

  adder_nbit #(
    .BIT_WIDTH(ChunkW)
  ) u_chunk_add (
    .a       (a_chunk),
    .b       (b_chunk),
    .carry_in(carry_q),
    .sum     (chunk_sum),
    .overflow(chunk_cout)
  );

  // Result with the current chunk merged in; kept separate from the mux block
  // so the adder sits between two combinational processes, not inside one.
  always_comb begin
    result_d = result_q;
    for (int unsigned i = 0; i < NumChunks; i++) begin
      if (idx_q == IdxW'(i)) begin
        result_d[i*ChunkW +: ChunkW] = chunk_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      result_q   <= '0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_q <= CALC;
        end
        CALC: begin
          result_q <= result_d;
          carry_q  <= chunk_cout;
          if (idx_q == LastIdx) begin
            // Final chunk: the completed word is published in one step, so
            // partial sums never reach the output.
            sum_q      <= result_d;
            overflow_q <= chunk_cout;
            idx_q      <= '0;
            state_q    <= DONE;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        DONE: begin
          state_q <= start ? CALC : IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Exclusive with the CALC branch above, which is the only other writer.
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= carry_in;
        idx_q   <= '0;
      end
    end
  end

  assign busy     = (state_q == CALC);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_adder_nbit_serial.sv
// tb_adder_nbit_serial
//   Three instances (CHUNK_BITS = 1, 4, 16) of the 16-bit serial adder.
//   Index k: 0 -> CHUNK_BITS 1, 1 -> CHUNK_BITS 4, 2 -> CHUNK_BITS 16.
//   Expected {overflow, sum} words are queued at issue time and popped by a
//   monitor whenever an instance pulses done.
module tb_adder_nbit_serial;
  import adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic [15:0] a, b;
  logic        cin;
  logic [2:0]  start_v;
  logic [2:0]  busy_v, done_v, ovf_v;
  logic [15:0] sum_a [3];

  int n_checks = 0;
  int n_pass   = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] q2[$];

  adder_nbit_serial #(.NUM_BITS(16), .CHUNK_BITS(1)) u_c1 (
    .clk(clk), .n_rst(n_rst), .start(start_v[0]), .a(a), .b(b), .carry_in(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_a[0]), .overflow(ovf_v[0])
  );
  adder_nbit_serial #(.NUM_BITS(16), .CHUNK_BITS(4)) u_c4 (
    .clk(clk), .n_rst(n_rst), .start(start_v[1]), .a(a), .b(b), .carry_in(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_a[1]), .overflow(ovf_v[1])
  );
  adder_nbit_serial #(.NUM_BITS(16), .CHUNK_BITS(16)) u_c16 (
    .clk(clk), .n_rst(n_rst), .start(start_v[2]), .a(a), .b(b), .carry_in(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_a[2]), .overflow(ovf_v[2])
  );

  function automatic int nch(input int k);
    case (k)
      0:       return 16;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input int k, input logic [16:0] e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  logic [16:0] mon_e;
  bit          mon_have;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_v[k] === 1'b1) begin
        mon_have = 1'b0;
        mon_e    = '0;
        case (k)
          0: if (q0.size() > 0) begin mon_e = q0.pop_front(); mon_have = 1'b1; end
          1: if (q1.size() > 0) begin mon_e = q1.pop_front(); mon_have = 1'b1; end
          default: if (q2.size() > 0) begin mon_e = q2.pop_front(); mon_have = 1'b1; end
        endcase
        if (!mon_have) chk($sformatf("unexpected_done_c%0d", k), 32'd1, 32'd0);
        else chk($sformatf("result_c%0d", k), {15'd0, ovf_v[k], sum_a[k]}, {15'd0, mon_e});
      end
    end
  end

  // Issue one add on instance k and wait (bounded) for its done pulse.
  // Returns at the falling edge inside the DONE cycle, so a following call is
  // accepted straight from DONE.
  task automatic go(input int k, input logic [15:0] ta, input logic [15:0] tb_,
                    input logic tc, input logic [16:0] e);
    int cyc;
    int bsy;
    a = ta;
    b = tb_;
    cin = tc;
    start_v[k] = 1'b1;
    push(k, e);
    tick();
    start_v[k] = 1'b0;
    cyc = 0;
    bsy = 0;
    while (cyc < 64) begin
      @(negedge clk);
      if (done_v[k] === 1'b1) break;
      if (busy_v[k] === 1'b1) bsy++;
      cyc++;
    end
    chk($sformatf("latency_c%0d", k), cyc, nch(k));
    chk($sformatf("busy_cycles_c%0d", k), bsy, nch(k));
  endtask

  logic [15:0] va [5] = '{16'h0000, 16'hFFFF, 16'h0008, 16'hFFFE, 16'h0003};
  logic [15:0] vb [5] = '{16'h0000, 16'h0004, 16'hFFFF, 16'hFFFD, 16'h0004};
  logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [16:0] ve [5] = '{17'h00000, 17'h10003, 17'h10007, 17'h1FFFC, 17'h00007};

  initial begin
    int dcnt;
    int bcnt;
    logic [15:0] ra, rb;
    logic        rc;

    // Reset held with start high: nothing may start.
    n_rst   = 1'b0;
    start_v = 3'b111;
    a = 16'h1234;
    b = 16'h4321;
    cin = 1'b1;
    tick();
    tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy_c%0d", k), {31'd0, busy_v[k]}, 32'd0);
      chk($sformatf("rst_done_c%0d", k), {31'd0, done_v[k]}, 32'd0);
      chk($sformatf("rst_sum_c%0d", k), {16'd0, sum_a[k]}, 32'd0);
      chk($sformatf("rst_ovf_c%0d", k), {31'd0, ovf_v[k]}, 32'd0);
    end
    chk("rst_no_calc", {31'd0, (u_c4.state_q == CALC)}, 32'd0);
    start_v = 3'b000;
    n_rst   = 1'b1;
    tick();
    tick();

    // Directed vectors on every configuration, with an idle gap between them.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) begin
        go(k, va[i], vb[i], vc[i], ve[i]);
        tick();
        tick();
      end
    end

    // Start pulsed mid-CALC with operands changed: captured values win, one done.
    push(1, 17'h02345);
    a = 16'h1234;
    b = 16'h1111;
    cin = 1'b0;
    start_v[1] = 1'b1;
    tick();
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    tick();
    start_v[1] = 1'b0;
    dcnt = 0;
    while (dcnt < 64) begin
      @(negedge clk);
      if (done_v[1] === 1'b1) break;
      dcnt++;
    end
    chk("midcalc_latency", dcnt, 3);
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_v[1] === 1'b1) dcnt++;
      if (busy_v[1] === 1'b1) bcnt++;
    end
    chk("midcalc_single_done", dcnt, 0);
    chk("midcalc_no_restart", bcnt, 0);

    // Back-to-back: second start sampled on the DONE cycle edge.
    go(1, 16'h0003, 16'h0004, 1'b0, 17'h00007);
    go(1, 16'h00FF, 16'h0001, 1'b0, 17'h00100);

    // Reset during the second CALC cycle: no done, outputs cleared.
    a = 16'hABCD;
    b = 16'h0001;
    cin = 1'b0;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    @(negedge clk);
    chk("midrst_sum", {16'd0, sum_a[1]}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf_v[1]}, 32'd0);
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_v[1] === 1'b1) dcnt++;
      if (busy_v[1] === 1'b1) bcnt++;
      @(negedge clk);
    end
    chk("midrst_no_done", dcnt, 0);
    chk("midrst_no_busy", bcnt, 0);
    go(1, 16'h0001, 16'h0001, 1'b1, 17'h00003);
    tick();
    tick();

    // Random sweep, reference is the plain 17-bit sum.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        go(k, ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'd0, rc});
      end
      tick();
      tick();
    end

    tick();
    chk("queues_drained", q0.size() + q1.size() + q2.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
